// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues word-aligned fetches under a credit limit,
// buffers in-order responses with their PCs, and flushes on redirect.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req_valid_o,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_req_ready_i,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   input  logic        stall_i,
   output logic        valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [AW-1:0] q_head_q, q_head_d;
   logic [AW-1:0] q_tail_q, q_tail_d;
   logic [AW-1:0] pf_head_q, pf_head_d;
   logic [AW-1:0] pf_tail_q, pf_tail_d;

   logic [31:0] q_pc_mem    [DEPTH];
   logic [31:0] q_instr_mem [DEPTH];
   logic [31:0] pf_mem      [DEPTH];

   logic [CW:0] used;
   logic        accept;
   logic        rsp;
   logic        push;
   logic        pop;

   // Credits cover both buffered and outstanding words, so the queue can never overflow.
   assign used             = {1'b0, count_q} + {1'b0, inflight_q};
   assign imem_req_valid_o = !rst_i && !redirect_i && (used < (CW+1)'(DEPTH));
   assign imem_req_addr_o  = fetch_pc_q;

   assign accept = imem_req_valid_o && imem_req_ready_i;
   assign rsp    = imem_rsp_valid_i;
   assign push   = rsp && !redirect_i && (drop_q == '0);
   assign pop    = valid_o && !stall_i && !redirect_i;

   assign valid_o = !rst_i && (count_q != '0);
   assign pc_o    = valid_o ? q_pc_mem[q_head_q]    : 32'h0;
   assign instr_o = valid_o ? q_instr_mem[q_head_q] : 32'h0;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      drop_d     = drop_q;
      q_head_d   = q_head_q;
      q_tail_d   = q_tail_q;
      pf_head_d  = pf_head_q;
      pf_tail_d  = pf_tail_q;
      inflight_d = inflight_q + CW'(accept) - CW'(rsp);

      if (accept) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
         pf_tail_d  = pf_tail_q + AW'(1);
      end
      // The address FIFO pops on every response, dropped or kept, to stay aligned.
      if (rsp) pf_head_d = pf_head_q + AW'(1);

      if (redirect_i) begin
         count_d    = '0;
         q_head_d   = '0;
         q_tail_d   = '0;
         fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
         drop_d     = inflight_d;
      end else begin
         if (rsp && (drop_q != '0)) drop_d = drop_q - CW'(1);
         if (push) q_tail_d = q_tail_q + AW'(1);
         if (pop)  q_head_d = q_head_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
         q_head_q   <= '0;
         q_tail_q   <= '0;
         pf_head_q  <= '0;
         pf_tail_q  <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         q_head_q   <= q_head_d;
         q_tail_q   <= q_tail_d;
         pf_head_q  <= pf_head_d;
         pf_tail_q  <= pf_tail_d;
      end
   end

   // NOTE: storage arrays are not reset; pointers and count define which entries are live.
   always_ff @(posedge clk_i) begin
      if (push) begin
         q_pc_mem[q_tail_q]    <= pf_mem[pf_head_q];
         q_instr_mem[q_tail_q] <= imem_rsp_data_i;
      end
      if (accept) pf_mem[pf_tail_q] <= fetch_pc_q;
   end

endmodule
